// File: rtl/td4_ctrl_pkg.sv
// Shared encodings for the TD4 run controller: FSM states, command codes
// and tick-divider rate selections.
package td4_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_LOAD = 2'b11
    } run_state_t;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_HALT = 2'b11;

    localparam logic [1:0] DIV_1   = 2'b00;
    localparam logic [1:0] DIV_4   = 2'b01;
    localparam logic [1:0] DIV_16  = 2'b10;
    localparam logic [1:0] DIV_MAX = 2'b11;

endpackage

// File: rtl/td4_tick_div.sv
// Free-running tick divider: one-cycle registered tick every 1, 4, 16 or
// 2^DIV_W cycles; any change of div_sel restarts a full period.
module td4_tick_div
    import td4_ctrl_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] div_sel,
    output logic       tick
);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] last;
    logic [1:0]       sel_seen;

    always_comb begin
        case (div_sel)
            DIV_1:   last = '0;
            DIV_4:   last = DIV_W'(3);
            DIV_16:  last = DIV_W'(15);
            default: last = '1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            sel_seen <= DIV_1;
            tick     <= 1'b0;
        end else if (div_sel != sel_seen) begin
            // rate change: drop the old phase and count a whole new period
            count    <= '0;
            sel_seen <= div_sel;
            tick     <= 1'b0;
        end else if (count == last) begin
            count    <= '0;
            tick     <= 1'b1;
        end else begin
            count    <= count + DIV_W'(1);
            tick     <= 1'b0;
        end
    end

endmodule

// File: rtl/td4_run_ctrl.sv
// Run/step/halt/program-load controller for a TD4 core: gates the core clock
// enable, holds the core in reset while loading, and writes program bytes.
module td4_run_ctrl
    import td4_ctrl_pkg::*;
#(
    parameter int DIV_W     = 8,
    parameter int ROM_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    input  logic [1:0] div_sel,
    input  logic       load_en,
    input  logic       load_strobe,
    input  logic [7:0] load_data,
    input  logic       bp_en,
    input  logic [3:0] bp_addr,
    input  logic [3:0] pc,
    output logic       cpu_ce,
    output logic       cpu_rst_n,
    output logic       rom_we,
    output logic [3:0] rom_addr,
    output logic [7:0] rom_wdata,
    output logic [1:0] state
);

    localparam logic [3:0] LAST_ADDR = 4'(ROM_DEPTH - 1);

    run_state_t cur_state, nxt_state;
    logic       tick;
    logic [3:0] ptr, ptr_next, addr_next;
    logic [7:0] wdata_next;
    logic       ce_next, we_next, rst_next;
    logic       issued, issued_next;
    logic       load_block, block_next;
    logic       halt_cmd, bp_hit;

    td4_tick_div #(.DIV_W(DIV_W)) u_tick_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .div_sel (div_sel),
        .tick    (tick)
    );

    always_comb begin
        nxt_state   = cur_state;
        ce_next     = 1'b0;
        we_next     = 1'b0;
        ptr_next    = ptr;
        wdata_next  = rom_wdata;
        issued_next = issued;
        block_next  = load_block & load_en;
        halt_cmd    = cmd_valid && (cmd == CMD_HALT);
        // a hit needs at least one instruction executed in this run
        bp_hit      = bp_en && (pc == bp_addr) && issued;

        case (cur_state)
            ST_HALT: begin
                if (load_en && !load_block) begin
                    nxt_state = ST_LOAD;
                    ptr_next  = '0;
                end else if (cmd_valid && cmd == CMD_RUN) begin
                    nxt_state   = ST_RUN;
                    issued_next = 1'b0;
                end else if (cmd_valid && cmd == CMD_STEP) begin
                    nxt_state = ST_STEP;
                end
            end
            ST_RUN: begin
                if (halt_cmd) begin
                    nxt_state = ST_HALT;
                end else if (tick) begin
                    if (bp_hit) begin
                        nxt_state = ST_HALT;
                    end else begin
                        ce_next     = 1'b1;
                        issued_next = 1'b1;
                    end
                end
            end
            ST_STEP: begin
                if (halt_cmd) begin
                    nxt_state = ST_HALT;
                end else if (tick) begin
                    ce_next   = 1'b1;
                    nxt_state = ST_HALT;
                end
            end
            ST_LOAD: begin
                if (!load_en) begin
                    nxt_state = ST_HALT;
                    ptr_next  = '0;
                end else if (load_strobe) begin
                    we_next    = 1'b1;
                    wdata_next = load_data;
                    if (ptr == LAST_ADDR) begin
                        // full image written: leave and wait for load_en to drop
                        ptr_next   = '0;
                        nxt_state  = ST_HALT;
                        block_next = 1'b1;
                    end else begin
                        ptr_next = ptr + 4'd1;
                    end
                end
            end
            default: nxt_state = ST_HALT;
        endcase

        addr_next = we_next ? ptr : ptr_next;
        rst_next  = (nxt_state != ST_LOAD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state  <= ST_HALT;
            cpu_ce     <= 1'b0;
            cpu_rst_n  <= 1'b0;
            rom_we     <= 1'b0;
            rom_addr   <= '0;
            rom_wdata  <= '0;
            ptr        <= '0;
            issued     <= 1'b0;
            load_block <= 1'b0;
        end else begin
            cur_state  <= nxt_state;
            cpu_ce     <= ce_next;
            cpu_rst_n  <= rst_next;
            rom_we     <= we_next;
            rom_addr   <= addr_next;
            rom_wdata  <= wdata_next;
            ptr        <= ptr_next;
            issued     <= issued_next;
            load_block <= block_next;
        end
    end

    assign state = cur_state;

endmodule
